ex_mem_reg: RTL
===============

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of PC fields.
REQ-002 Parameter DATA_WIDTH, default 32, width of data fields.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 flush  in  1  synchronous kill of all held instructions.
REQ-006 in_valid  in  1; in_ready  out  1  upstream (EX) handshake.
REQ-007 in_alu_result, in_store_data  in  DATA_WIDTH each; in_pc  in  ADDR_WIDTH.
REQ-008 in_rd_addr  in  5; in_reg_write, in_mem_read, in_mem_write  in  1 each; in_mem_be  in  4; in_wb_sel  in  2.
REQ-009 out_valid  out  1; out_ready  in  1  downstream (MEM) handshake.
REQ-010 out_* outputs mirror every in_* payload field above, same widths.
REQ-011 fwd_valid  out  1; fwd_rd_addr  out  5; fwd_data  out  DATA_WIDTH  forwarding source to ID/EX operand muxes.
REQ-012 stall_cnt  out  16  count of downstream-stall cycles.

Function
REQ-013 Transfer in = in_valid && in_ready; transfer out = out_valid && out_ready.
REQ-014 Two payload slots, MAIN (drives out_*) and SKID; state EMPTY, ONE, TWO.
REQ-015 in_ready SHALL be a registered signal, 1 in EMPTY/ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-016 out_valid = 1 in ONE/TWO, 0 in EMPTY.
REQ-017 EMPTY: in transfer -> MAIN<=in, ONE; else stay.
REQ-018 ONE: in+out -> MAIN<=in, stay ONE; in only -> SKID<=in, TWO; out only -> EMPTY; neither -> hold.
REQ-019 TWO: out transfer -> MAIN<=SKID, ONE; else hold all.
REQ-020 Latency: accepted instruction appears on out_* the cycle after acceptance when MAIN is free; order strictly FIFO.
REQ-021 flush has priority over all transfers: next state EMPTY, any same-cycle in transfer discarded, in_ready=1 next cycle.
REQ-022 Payload slots not cleared on flush; out_reg_write, out_mem_read, out_mem_write SHALL be forced 0 whenever out_valid=0.
REQ-023 fwd_valid = out_valid && out_reg_write && out_rd_addr!=0; fwd_rd_addr=out_rd_addr; fwd_data=out_alu_result.
REQ-024 stall_cnt increments each cycle out_valid && !out_ready, saturates at 16'hFFFF, unaffected by flush.
REQ-025 Payload fields passed bit-exact; no arithmetic on data.

Reset
REQ-026 Reset asserted: state EMPTY, in_ready=1, out_valid=0, fwd_valid=0, all payload slots and stall_cnt 0.
REQ-027 Reset asserted mid-transfer discards all held instructions; no transfer completes in the deassertion cycle's preceding edge.
REQ-028 First in transfer possible on first rising edge after deassertion.

Structure
REQ-029 Shared package exmem_pkg: payload struct (all in_* fields), state enum, WB_SEL encodings (ALU=0, MEM=1, PC4=2).
REQ-030 One sub-module natural: pipe_skid_buf, generic two-slot skid buffer parameterized by payload width; ex_mem_reg adds flush gating, forwarding, counter.

Verification
REQ-031 Reset, then in_valid=1 alu=0x1234, rd=5, reg_write=1, out_ready=1 -> next cycle out_valid=1, fwd_valid=1, fwd_rd_addr=5, fwd_data=0x1234.
REQ-032 out_ready=0, push A, B -> in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready=1 after A drains.
REQ-033 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, out_mem_write=0, C never emitted, in_ready=1.
REQ-034 Instruction rd=0, reg_write=1 -> fwd_valid=0 while out_valid=1.
REQ-035 out_valid=1, out_ready=0 held 70000 cycles -> stall_cnt stops at 0xFFFF; flush leaves it unchanged.
REQ-036 Assert reset in TWO between edges -> out_valid, fwd_valid drop to 0 immediately, in_ready=1.

Source files
------------

// File: rtl/exmem_pkg.sv
// rtl/exmem_pkg.sv - shared types for the EX/MEM pipeline register
// Control portion of the payload; data and PC fields are appended by width parameters in the top.
package exmem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_be;
    wb_sel_e    wb_sel;
  } exmem_ctrl_t;

  localparam int CTRL_W = $bits(exmem_ctrl_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic two-slot skid buffer with registered ready
// MAIN always drives out_data; SKID catches the beat accepted while MAIN is stalled.
module pipe_skid_buf
  import exmem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_e       state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_ready_q, out_valid_q;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire)      state_nxt = ST_TWO;
          else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (out_fire) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Ready/valid are derived from the next state so neither depends combinationally on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != ST_TWO);
      out_valid_q <= (state_nxt != ST_EMPTY);
      if (!clear) begin
        case (state)
          ST_EMPTY: if (in_fire) main_q <= in_data;
          ST_ONE: begin
            if (in_fire && out_fire) main_q <= in_data;
            else if (in_fire)        skid_q <= in_data;
          end
          ST_TWO:   if (out_fire) main_q <= skid_q;
          default:  ;
        endcase
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with flush, forwarding and stall counter
// Wraps the skid buffer; flush empties it without clearing payload storage.
module ex_mem_reg
  import exmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [4:0]            in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [3:0]            in_mem_be,
  input  logic [1:0]            in_wb_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [4:0]            out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [3:0]            out_mem_be,
  output logic [1:0]            out_wb_sel,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [15:0]           stall_cnt
);

  localparam int PW = 2 * DATA_WIDTH + ADDR_WIDTH + CTRL_W;

  exmem_ctrl_t   in_ctrl, out_ctrl;
  logic [PW-1:0] in_pl, out_pl;
  logic          buf_valid;
  logic [15:0]   stall_q;

  always_comb begin
    in_ctrl           = '0;
    in_ctrl.rd_addr   = in_rd_addr;
    in_ctrl.reg_write = in_reg_write;
    in_ctrl.mem_read  = in_mem_read;
    in_ctrl.mem_write = in_mem_write;
    in_ctrl.mem_be    = in_mem_be;
    in_ctrl.wb_sel    = wb_sel_e'(in_wb_sel);
  end

  assign in_pl = {in_alu_result, in_store_data, in_pc, in_ctrl};

  pipe_skid_buf #(
    .WIDTH(PW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (buf_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign {out_alu_result, out_store_data, out_pc, out_ctrl} = out_pl;

  // Stale payload stays in MAIN after flush, so side-effect strobes must be masked by valid.
  assign out_valid      = buf_valid;
  assign out_rd_addr    = out_ctrl.rd_addr;
  assign out_reg_write  = buf_valid && out_ctrl.reg_write;
  assign out_mem_read   = buf_valid && out_ctrl.mem_read;
  assign out_mem_write  = buf_valid && out_ctrl.mem_write;
  assign out_mem_be     = out_ctrl.mem_be;
  assign out_wb_sel     = out_ctrl.wb_sel;

  assign fwd_valid   = out_reg_write && (out_ctrl.rd_addr != 5'd0);
  assign fwd_rd_addr = out_ctrl.rd_addr;
  assign fwd_data    = out_alu_result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (buf_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;

endmodule
